inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Instruction fetch front end and master of the instruction SRAM port.
//   Drives en/wen/addr/wdata of the 1-cycle-latency synchronous SRAM and
//   captures rdata one cycle after each issue. Buffers fetched {pc, inst}
//   pairs in a small FIFO and presents them to decode over valid/ready.
//   Accepts branch redirects and discards stale fetches.
// PARAMETERS
//   RESET_PC    32'hbfc0_0000  PC of the first fetch after reset
//   ADDR_WIDTH  18             SRAM word-address width; addr = pc[ADDR_WIDTH+1:2]
//   FIFO_DEPTH  2              output FIFO entries (power of 2, >=2)
// PORTS
//   clk             in   1           single clock, all state on posedge
//   resetn          in   1           synchronous reset, active low
//   br_taken        in   1           redirect pulse, valid for one cycle
//   br_target       in   32          redirect PC; bits [1:0] ignored (treated as 0)
//   out_valid       out  1           FIFO head valid
//   out_ready       in   1           decode accepts head
//   out_pc          out  32          PC of head entry
//   out_inst        out  32          instruction word of head entry
//   inst_sram_en    out  1           SRAM enable (read request)
//   inst_sram_wen   out  4           byte write enables, constant 4'b0
//   inst_sram_addr  out  ADDR_WIDTH  SRAM word address
//   inst_sram_wdata out  32          constant 32'b0
//   inst_sram_rdata in   32          SRAM read data, valid cycle after en
// BEHAVIOUR
//   Reset (resetn=0 at posedge): pc<=RESET_PC, FIFO empty, inflight<=0,
//     kill<=0. out_valid=0; inst_sram_en=0 while resetn=0 (gated combinationally).
//   pop   = out_valid & out_ready.
//   issue = resetn & ~br_taken & (count - pop + inflight < FIFO_DEPTH).
//   inst_sram_en = issue; inst_sram_addr = pc[ADDR_WIDTH+1:2] (combinational).
//   On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 (32-bit wrap at 2^32).
//   No issue: inflight<=0.
//   Read latency: issue at cycle t -> rdata sampled at t+1 -> entry
//     {inflight_pc, rdata} pushed at end of t+1 -> visible at out_* in t+2.
//   Push at t+1 iff inflight & ~kill & ~br_taken. Credit check guarantees
//     a push never finds the FIFO full; push and pop in one cycle are legal.
//   Throughput: out_ready held 1 -> one instruction per cycle sustained.
//   Redirect (br_taken=1 in cycle r):
//     - pop in cycle r still completes (decode owns that instruction).
//     - FIFO cleared at end of r (count<=0); no push at end of r.
//     - no issue in r; pc<=br_target & ~32'h3.
//     - request issued in r-1 (data in r) discarded; kill only needed
//       if flush and arrival fall in different cycles, so kill stays 0.
//     - first fetch of target issued in r+1; its out_valid in r+3.
//   Back-to-back br_taken: last one wins, no issue until br_taken=0.
//   out_ready=0: FIFO fills; issue stops once count+inflight=FIFO_DEPTH.
//     Resumes in the cycle pop occurs. No data lost or duplicated.
//   out_pc/out_inst hold stable while out_valid=1 and out_ready=0.
//   Reset mid-operation: all state returns to reset values next edge.
//     In-flight SRAM data is ignored. en is low during every reset cycle.
// TESTING
//   1. Reset release, out_ready=1: en=1 addr=RESET_PC>>2 in cycle 0;
//      out_pc=bfc00000 in cycle 2; then bfc00004, bfc00008, one per cycle.
//   2. out_ready=0 from reset: exactly 2 issues (bfc00000, bfc00004), then
//      en=0. Raise out_ready: pops in order, fetch resumes at bfc00008.
//   3. br_taken with br_target=8000_1003 while a fetch is in flight:
//      in-flight word never appears; next out_pc=8000_1000, 2 cycles
//      after the redirect-plus-1 issue.
//   4. br_taken with pop in same cycle: popped entry counts once; FIFO
//      then empty. Back-to-back br_taken (A then B): only B stream appears.
//   5. resetn low for 1 cycle mid-stream: en=0 that cycle; out_valid=0
//      next; fetch restarts at RESET_PC.
//   6. pc=ffff_fffc fetch: next pc wraps to 0000_0000; wen=0, wdata=0 always.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch front end driving a 1-cycle-latency SRAM,
// buffering {pc, inst} pairs in a small FIFO for decode, with branch redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
    parameter int          ADDR_WIDTH = 18,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_inst,
    output logic                  inst_sram_en,
    output logic [3:0]            inst_sram_wen,
    output logic [ADDR_WIDTH-1:0] inst_sram_addr,
    output logic [31:0]           inst_sram_wdata,
    input  logic [31:0]           inst_sram_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d, inflight_pc_q;
    logic          inflight_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, wr_q;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [CW:0]   credit;
    logic          pop, push, issue;

    assign out_valid = count_q != '0;
    assign pop       = out_valid & out_ready;
    // Slots already promised: buffered entries not leaving now plus the word on its way back.
    assign credit    = {1'b0, count_q} - (CW+1)'(pop) + (CW+1)'(inflight_q);
    assign issue     = resetn & ~br_taken & (credit < (CW+1)'(FIFO_DEPTH));
    assign push      = inflight_q & ~br_taken;
    assign pc_d      = br_taken ? (br_target & ~32'h3) : issue ? pc_q + 32'd4 : pc_q;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    assign inst_sram_en    = issue;
    assign inst_sram_addr  = pc_q[ADDR_WIDTH+1:2];
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_wdata = 32'b0;
    assign out_pc          = mem_q[rd_q][63:32];
    assign out_inst        = mem_q[rd_q][31:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
            if (br_taken) begin
                count_q <= '0;
                rd_q    <= '0;
                wr_q    <= '0;
            end else begin
                count_q <= count_d;
                if (push) wr_q <= wr_q + PW'(1);
                if (pop) rd_q <= rd_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) mem_q[wr_q] <= {inflight_pc_q, inst_sram_rdata};
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed-step bench for inst_fetch with a behavioural
// 1-cycle SRAM whose word at address a is {12'h0, a, 2'b00} ^ 32'h5a5a5a5a.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc, out_inst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [17:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'hdead_beef;

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [31:0] SCRAMBLE = 32'h5a5a_5a5a;

    inst_fetch dut (
        .clk(clk), .resetn(resetn), .br_taken(br_taken), .br_target(br_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? ({12'h0, inst_sram_addr, 2'b00} ^ SCRAMBLE) : 32'hdead_beef;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {12'h0, pc[19:2], 2'b00} ^ SCRAMBLE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic br, input logic rdy, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        resetn = rn;
        br_taken = br;
        out_ready = rdy;
        br_target = tgt;
        #1;
        chk("wen", {28'h0, inst_sram_wen}, 32'h0);
        chk("wdata", inst_sram_wdata, 32'h0);
    endtask

    task automatic en_is(input string tag, input logic e, input logic [31:0] pc);
        chk({tag, ".en"}, {31'h0, inst_sram_en}, {31'h0, e});
        if (e) chk({tag, ".addr"}, {14'h0, inst_sram_addr}, {14'h0, pc[19:2]});
    endtask

    task automatic head(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".inst"}, out_inst, word_at(pc));
    endtask

    task automatic empty(input string tag);
        chk({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        // reset held
        cyc(0, 0, 1, 0); en_is("rst0", 0, 0);
        cyc(0, 0, 1, 0); en_is("rst1", 0, 0); empty("rst1");
        // 1: streaming from reset
        cyc(1, 0, 1, 0); en_is("t1c0", 1, 32'hbfc00000); empty("t1c0");
        cyc(1, 0, 1, 0); en_is("t1c1", 1, 32'hbfc00004); empty("t1c1");
        cyc(1, 0, 1, 0); en_is("t1c2", 1, 32'hbfc00008); head("t1c2", 32'hbfc00000);
        cyc(1, 0, 1, 0); head("t1c3", 32'hbfc00004);
        cyc(1, 0, 1, 0); head("t1c4", 32'hbfc00008);
        // 2: decode stalled from reset
        cyc(0, 0, 0, 0); en_is("t2rst", 0, 0);
        cyc(1, 0, 0, 0); en_is("t2c0", 1, 32'hbfc00000); empty("t2c0");
        cyc(1, 0, 0, 0); en_is("t2c1", 1, 32'hbfc00004);
        cyc(1, 0, 0, 0); en_is("t2c2", 0, 0); head("t2c2", 32'hbfc00000);
        cyc(1, 0, 0, 0); en_is("t2c3", 0, 0); head("t2c3", 32'hbfc00000);
        cyc(1, 0, 0, 0); en_is("t2c4", 0, 0); head("t2c4", 32'hbfc00000);
        cyc(1, 0, 1, 0); en_is("t2c5", 1, 32'hbfc00008); head("t2c5", 32'hbfc00000);
        cyc(1, 0, 1, 0); en_is("t2c6", 1, 32'hbfc0000c); head("t2c6", 32'hbfc00004);
        cyc(1, 0, 1, 0); head("t2c7", 32'hbfc00008);
        cyc(1, 0, 1, 0); head("t2c8", 32'hbfc0000c);
        // 3: redirect with a fetch in flight
        cyc(0, 0, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0); head("t3c2", 32'hbfc00000);
        cyc(1, 1, 1, 32'h80001003); en_is("t3r", 0, 0); head("t3r", 32'hbfc00004);
        cyc(1, 0, 1, 0); en_is("t3r1", 1, 32'h80001000); empty("t3r1");
        cyc(1, 0, 1, 0); en_is("t3r2", 1, 32'h80001004); empty("t3r2");
        cyc(1, 0, 1, 0); head("t3r3", 32'h80001000);
        cyc(1, 0, 1, 0); head("t3r4", 32'h80001004);
        // 4: redirect with pop in the same cycle, then back-to-back redirects
        cyc(1, 1, 1, 32'h00002000); en_is("t4a", 0, 0); head("t4a", 32'h80001008);
        cyc(1, 1, 1, 32'h00003000); en_is("t4b", 0, 0); empty("t4b");
        cyc(1, 0, 1, 0); en_is("t4c", 1, 32'h00003000); empty("t4c");
        cyc(1, 0, 1, 0); en_is("t4d", 1, 32'h00003004); empty("t4d");
        cyc(1, 0, 1, 0); head("t4e", 32'h00003000);
        cyc(1, 0, 1, 0); head("t4f", 32'h00003004);
        // 5: one-cycle reset mid-stream
        cyc(0, 0, 1, 0); en_is("t5rst", 0, 0);
        cyc(1, 0, 1, 0); empty("t5c0"); en_is("t5c0", 1, 32'hbfc00000);
        cyc(1, 0, 1, 0); empty("t5c1"); en_is("t5c1", 1, 32'hbfc00004);
        cyc(1, 0, 1, 0); head("t5c2", 32'hbfc00000);
        // 6: pc wrap at the top of the address space
        cyc(1, 1, 1, 32'hffff_fffc); en_is("t6r", 0, 0);
        cyc(1, 0, 1, 0); en_is("t6c0", 1, 32'hffff_fffc);
        cyc(1, 0, 1, 0); en_is("t6c1", 1, 32'h0000_0000);
        cyc(1, 0, 1, 0); head("t6c2", 32'hffff_fffc);
        cyc(1, 0, 1, 0); head("t6c3", 32'h0000_0000);
        cyc(1, 0, 1, 0); head("t6c4", 32'h0000_0004);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
